// File: rtl/ps2_direction_decoder_pkg.sv
// Shared snake-game constants: direction encoding, PS/2 scan codes and receiver states.
// Imported by the PS/2 receiver, the direction decoder top and the game control block.
package snake_pkg;

    localparam logic [1:0] LEFT  = 2'd0;
    localparam logic [1:0] RIGHT = 2'd1;
    localparam logic [1:0] UP    = 2'd2;
    localparam logic [1:0] DOWN  = 2'd3;

    // Prefix bytes, then the E0-prefixed arrow codes and the plain WASD codes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_direction_decoder_if.sv
// Bundle of the raw PS/2 pins and the decoded direction outputs.
// master = keyboard side / consumer, slave = the decoder block.
interface ps2_direction_decoder_if;

    logic       ps2_clk;
    logic       ps2_dat;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic [1:0] dir;
    logic       dir_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_dat,
        input  left, right, up, down, dir, dir_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat,
        output left, right, up, down, dir, dir_valid, frame_err
    );

endinterface

// File: rtl/ps2_direction_decoder_rx.sv
// PS/2 byte receiver: synchronizes the raw pins, detects ps2_clk falls and
// frames start/8 data/odd parity/stop bits, abandoning stalled frames after TIMEOUT_CYCLES.
module ps2_rx
    import snake_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]  clk_sync_q, clk_sync_d;
    logic [1:0]  dat_sync_q, dat_sync_d;
    logic        fall_q, fall_d;
    logic        bit_q, bit_d;
    rx_state_e   state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_err_q, frame_err_d;

    // fall and its data bit are registered together so the sample lines up with the edge
    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_dat};
        fall_d     = clk_sync_q[2] & ~clk_sync_q[1];
        bit_d      = dat_sync_q[1];
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == RX_IDLE) begin
            to_cnt_d = '0;
            if (fall_q && !bit_q) begin
                state_d   = RX_DATA;
                bit_cnt_d = 3'd0;
            end
        end else if (fall_q) begin
            to_cnt_d = '0;
            unique case (state_q)
                RX_DATA: begin
                    shift_d = {bit_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                RX_PARITY: begin
                    parity_d = bit_q;
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    if (bit_q && parity_ok(shift_q, parity_q)) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
            // Stalled mid-frame: drop the partial byte and report it
            state_d     = RX_IDLE;
            to_cnt_d    = '0;
            frame_err_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // Synchronizers reset to the idle-high line level so release never fakes a fall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q   <= 3'b111;
            dat_sync_q   <= 2'b11;
            fall_q       <= 1'b0;
            bit_q        <= 1'b1;
            state_q      <= RX_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            fall_q       <= fall_d;
            bit_q        <= bit_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_direction_decoder.sv
// Turns PS/2 keyboard frames into held left/right/up/down levels and a latched dir.
// Define PS2_WASD_EN to also decode the plain (non-E0) WASD keys.
module ps2_direction_decoder
    import snake_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    resetn,
    ps2_direction_decoder_if.slave  bus
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_err;

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [3:0] held_q, held_d;
    logic [1:0] dir_q, dir_d;
    logic       dir_valid_q, dir_valid_d;

    logic       key_hit;
    logic [1:0] key_dir;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (bus.ps2_clk),
        .ps2_dat    (bus.ps2_dat),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (rx_err)
    );

    // Map the received byte to a direction; arrows need the E0 prefix, WASD must not have it
    always_comb begin
        key_hit = 1'b0;
        key_dir = RIGHT;
        if (ext_q) begin
            case (rx_byte)
                SC_LEFT:  begin key_hit = 1'b1; key_dir = LEFT;  end
                SC_RIGHT: begin key_hit = 1'b1; key_dir = RIGHT; end
                SC_UP:    begin key_hit = 1'b1; key_dir = UP;    end
                SC_DOWN:  begin key_hit = 1'b1; key_dir = DOWN;  end
                default:  ;
            endcase
        end
`ifdef PS2_WASD_EN
        else begin
            case (rx_byte)
                SC_A:    begin key_hit = 1'b1; key_dir = LEFT;  end
                SC_D:    begin key_hit = 1'b1; key_dir = RIGHT; end
                SC_W:    begin key_hit = 1'b1; key_dir = UP;    end
                SC_S:    begin key_hit = 1'b1; key_dir = DOWN;  end
                default: ;
            endcase
        end
`endif
    end

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        held_d      = held_q;
        dir_d       = dir_q;
        dir_valid_d = 1'b0;

        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            case (rx_byte)
                SC_EXT:   ext_d = 1'b1;
                SC_BREAK: brk_d = 1'b1;
                default: begin
                    if (key_hit) begin
                        if (brk_q) begin
                            held_d[key_dir] = 1'b0;
                        end else begin
                            held_d[key_dir] = 1'b1;
                            dir_d           = key_dir;
                            dir_valid_d     = 1'b1;
                        end
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= 4'b0000;
            dir_q       <= RIGHT;
            dir_valid_q <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            held_q      <= held_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
        end
    end

    assign bus.left      = held_q[LEFT];
    assign bus.right     = held_q[RIGHT];
    assign bus.up        = held_q[UP];
    assign bus.down      = held_q[DOWN];
    assign bus.dir       = dir_q;
    assign bus.dir_valid = dir_valid_q;
    assign bus.frame_err = rx_err;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Self-checking bench for ps2_direction_decoder: directed key sequences from the
// test plan followed by random PS/2 frames, all checked against a frame-level key model.
module tb_ps2_direction_decoder;

    localparam int TO = 200;
    localparam int H  = 20;

    logic clk = 1'b0;
    logic resetn;

    ps2_direction_decoder_if bus ();

    ps2_direction_decoder #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Key-state model: held keys, last direction, pending prefixes and expected pulse counts
    bit       m_ext;
    bit       m_brk;
    bit [3:0] m_held;
    bit [1:0] m_dir;
    int       dv_exp;
    int       fe_exp;
    int       dv_count;
    int       fe_count;
    int       vectors;
    int       miscompares;
    bit       stable;

    logic [7:0] arrow_codes [4] = '{8'h6B, 8'h74, 8'h75, 8'h72};
    logic [7:0] wasd_codes  [4] = '{8'h1C, 8'h23, 8'h1D, 8'h1B};

    function automatic int lookupKey(input logic [7:0] code, input bit ext);
        for (int k = 0; k < 4; k++) begin
            if (ext && code == arrow_codes[k]) return k;
`ifdef PS2_WASD_EN
            if (!ext && code == wasd_codes[k]) return k;
`endif
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_ext    = 0;
        m_brk    = 0;
        m_held   = 4'b0000;
        m_dir    = 2'd1;
        dv_exp   = 0;
        fe_exp   = 0;
        dv_count = 0;
        fe_count = 0;
    endtask

    task automatic modelByte(input logic [7:0] b);
        int k;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            k = lookupKey(b, m_ext);
            if (k >= 0) begin
                if (m_brk) begin
                    m_held[k] = 1'b0;
                end else begin
                    m_held[k] = 1'b1;
                    m_dir     = 2'(k);
                    dv_exp++;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic modelErr();
        m_ext = 0;
        m_brk = 0;
        fe_exp++;
    endtask

    task automatic checkVal(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("dir_valid_count", dv_count, dv_exp);
        checkVal("frame_err_count", fe_count, fe_exp);
        checkVal("levels_dir", int'({bus.down, bus.up, bus.right, bus.left, bus.dir}),
                 int'({m_held, m_dir}));
    endtask

    // Sends the first nbits of a frame (start, 8 data LSB first, parity, stop)
    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                 input int nbits);
        logic [10:0] bits;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        bits[9]    = bad_par ? ^b : ~^b;
        bits[10]   = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            if (i == 10) stable = 0;
            bus.ps2_dat = bits[i];
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        if (nbits == 11) begin
            repeat (4) @(negedge clk);
            bus.ps2_dat = 1'b1;
            if (bad_par || bad_stop) modelErr();
            else modelByte(b);
            checkOutput();
            stable = 1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b, 1'b0, 1'b0, 11);
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, "_left"},      int'(bus.left),      0);
        checkVal({tag, "_right"},     int'(bus.right),     0);
        checkVal({tag, "_up"},        int'(bus.up),        0);
        checkVal({tag, "_down"},      int'(bus.down),      0);
        checkVal({tag, "_dir"},       int'(bus.dir),       1);
        checkVal({tag, "_dir_valid"}, int'(bus.dir_valid), 0);
        checkVal({tag, "_frame_err"}, int'(bus.frame_err), 0);
    endtask

    // Single compare process: counts pulses and checks levels/dir every settled cycle
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bus.dir_valid) dv_count++;
            if (bus.frame_err) fe_count++;
            if (bus.dir_valid || bus.frame_err)
                checkVal("pulse_overlap", int'(bus.dir_valid & bus.frame_err), 0);
            if (stable)
                checkVal("cycle_levels_dir", int'({bus.down, bus.up, bus.right, bus.left, bus.dir}),
                         int'({m_held, m_dir}));
        end
    end

    initial begin
        logic [7:0] b;
        int         r;
        vectors     = 0;
        miscompares = 0;
        stable      = 0;
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        resetn      = 1'b0;
        modelReset();
        repeat (5) @(negedge clk);
        checkResetValues("reset");
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        stable = 1;

        // Right arrow press and release
        sendByte(8'hE0);
        sendByte(8'h74);
        checkVal("right_press_right", int'(bus.right), 1);
        checkVal("right_press_dir", int'(bus.dir), 1);
        checkVal("right_press_dv", dv_count, 1);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h74);
        checkVal("right_release_right", int'(bus.right), 0);
        checkVal("right_release_dir", int'(bus.dir), 1);
        checkVal("right_release_dv", dv_count, 1);

        // Two keys held, then release up
        sendByte(8'hE0);
        sendByte(8'h75);
        sendByte(8'hE0);
        sendByte(8'h6B);
        checkVal("two_keys_up", int'(bus.up), 1);
        checkVal("two_keys_left", int'(bus.left), 1);
        checkVal("two_keys_dir", int'(bus.dir), 0);
        checkVal("two_keys_dv", dv_count, 3);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        checkVal("up_release_up", int'(bus.up), 0);
        checkVal("up_release_left", int'(bus.left), 1);
        checkVal("up_release_dir", int'(bus.dir), 0);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h6B);

        // Parity error after E0 drops the prefix
        sendByte(8'hE0);
        applyStimulus(8'h74, 1'b1, 1'b0, 11);
        checkVal("parity_err_fe", fe_count, 1);
        checkVal("parity_err_right", int'(bus.right), 0);
        sendByte(8'h74);
        checkVal("after_parity_right", int'(bus.right), 0);
        checkVal("after_parity_dv", dv_count, 3);

        // Timeout after 4 data bits
        applyStimulus(8'h72, 1'b0, 1'b0, 5);
        bus.ps2_dat = 1'b1;
        repeat (TO + 20) @(negedge clk);
        modelErr();
        checkOutput();
        checkVal("timeout_fe", fe_count, 2);
        sendByte(8'hE0);
        sendByte(8'h72);
        checkVal("after_timeout_down", int'(bus.down), 1);
        checkVal("after_timeout_dir", int'(bus.dir), 3);

        // Reset during bit 5 of an E0 frame
        stable = 0;
        applyStimulus(8'hE0, 1'b0, 1'b0, 6);
        bus.ps2_dat = 1'b1;
        repeat (H / 2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checkResetValues("mid_frame_reset");
        modelReset();
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        stable = 1;
        sendByte(8'hE0);
        sendByte(8'h6B);
        checkVal("post_reset_dir", int'(bus.dir), 0);
        checkVal("post_reset_left", int'(bus.left), 1);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h6B);

        // WASD 'W' press and release
        sendByte(8'h1D);
`ifdef PS2_WASD_EN
        checkVal("wasd_up", int'(bus.up), 1);
        checkVal("wasd_dir", int'(bus.dir), 2);
`else
        checkVal("wasd_up", int'(bus.up), 0);
        checkVal("wasd_dir", int'(bus.dir), 0);
`endif
        sendByte(8'hF0);
        sendByte(8'h1D);
        checkVal("wasd_release_up", int'(bus.up), 0);

        // Random traffic with occasional parity and stop-bit errors
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    b = 8'hE0;
                2:       b = 8'hF0;
                3, 4, 5, 6, 9: b = arrow_codes[$urandom_range(0, 3)];
                7:       b = wasd_codes[$urandom_range(0, 3)];
                default: b = 8'($urandom);
            endcase
            r = int'($urandom_range(0, 11));
            applyStimulus(b, r == 0, r == 1, 11);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
